// File: rtl/ptp_pkg.sv
// Shared constants for the PTP transmit scheduler: generator register map,
// default generator base address and the scheduler FSM state encoding.
package ptp_pkg;

   localparam logic [31:0] GEN_BASE_DEFAULT = 32'h0300_0100;

   localparam logic [31:0] OFS_CTRL = 32'h00;
   localparam logic [31:0] OFS_INFO = 32'h04;
   localparam logic [31:0] OFS_TSSH = 32'h08;
   localparam logic [31:0] OFS_TSSL = 32'h0C;
   localparam logic [31:0] OFS_TSNS = 32'h10;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_WR_INFO    = 3'd1,
      ST_WR_TSSH    = 3'd2,
      ST_WR_TSSL    = 3'd3,
      ST_WR_TSNS    = 3'd4,
      ST_WR_CTRL    = 3'd5,
      ST_GAP        = 3'd6,
      ST_WAIT_FRAME = 3'd7
   } state_e;

endpackage

// File: rtl/ptp_wb_wr_master.sv
// Single Wishbone write: start latches addr/data and raises stb/we, which stay
// up until ack is sampled; done is the accepting cycle (stb & ack).
module ptp_wb_wr_master (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] data_i,
   input  logic        ack_i,
   output logic        stb_o,
   output logic        we_o,
   output logic [31:0] addr_o,
   output logic [31:0] data_o,
   output logic        done_o
);

   logic        r_stb;
   logic [31:0] r_addr;
   logic [31:0] r_data;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_stb  <= 1'b0;
         r_addr <= 32'h0;
         r_data <= 32'h0;
      end else if (r_stb) begin
         if (ack_i) begin
            r_stb <= 1'b0;
         end
      end else if (start_i) begin
         r_stb  <= 1'b1;
         r_addr <= addr_i;
         r_data <= data_i;
      end
   end

   // ack outside a strobe is meaningless and must never complete a write
   assign done_o = r_stb & ack_i;
   assign stb_o  = r_stb;
   assign we_o   = r_stb;
   assign addr_o = r_addr;
   assign data_o = r_data;

endmodule

// File: rtl/ptp_tx_scheduler.sv
// PTP transmit scheduler: on a manual or periodic trigger, programs the frame
// generator (INFO, TSSH, TSSL, TSNS, CTRL) over Wishbone and waits for tlast.
module ptp_tx_scheduler
   import ptp_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 1024,
   parameter logic [31:0] GEN_BASE    = GEN_BASE_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable_i,
   input  logic [31:0] interval_i,
   input  logic        trig_i,
   input  logic [3:0]  msg_type_i,
   input  logic [47:0] tod_sec_i,
   input  logic [31:0] tod_ns_i,
   output logic [31:0] wbm_addr_o,
   output logic [31:0] wbm_data_o,
   output logic        wbm_we_o,
   output logic        wbm_stb_o,
   input  logic        wbm_ack_i,
   input  logic        mon_tvalid_i,
   input  logic        mon_tready_i,
   input  logic        mon_tlast_i,
   output logic        busy_o,
   output logic [15:0] seq_id_o,
   output logic [31:0] sent_cnt_o,
   output logic        overrun_o,
   output logic        timeout_o
);

   localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYC - 1);

   state_e      r_state;
   state_e      r_ret;
   logic [47:0] r_sec;
   logic [31:0] r_ns;
   logic [15:0] r_seq;
   logic [31:0] r_sent;
   logic        r_overrun;
   logic        r_timeout;
   logic        r_pending;
   logic        r_en_d;
   logic [31:0] r_period;
   logic [31:0] r_wait_cnt;

   logic        w_periodic;
   logic        w_trig;
   logic        w_go;
   logic        w_frame;
   logic        w_done;
   logic        w_start;
   logic [31:0] w_addr;
   logic [31:0] w_data;
   logic [31:0] w_reload;

   assign w_reload   = interval_i - 32'd1;
   assign w_periodic = enable_i && (interval_i != 32'd0) && (r_period == 32'd0);
   assign w_trig     = trig_i | w_periodic;
   assign w_go       = (r_state == ST_IDLE) && (w_trig || r_pending);
   assign w_frame    = mon_tvalid_i & mon_tready_i & mon_tlast_i;

   // The write is launched on the edge that enters each WR state, so GAP is
   // the only stb-low cycle between consecutive writes.
   always_comb begin
      w_start = 1'b0;
      w_addr  = 32'h0;
      w_data  = 32'h0;
      if (w_go) begin
         w_start = 1'b1;
         w_addr  = GEN_BASE + OFS_INFO;
         w_data  = {msg_type_i, 12'h0, r_seq};
      end else if (r_state == ST_GAP) begin
         w_start = 1'b1;
         case (r_ret)
            ST_WR_TSSH: begin
               w_addr = GEN_BASE + OFS_TSSH;
               w_data = {16'h0, r_sec[47:32]};
            end
            ST_WR_TSSL: begin
               w_addr = GEN_BASE + OFS_TSSL;
               w_data = r_sec[31:0];
            end
            ST_WR_TSNS: begin
               w_addr = GEN_BASE + OFS_TSNS;
               w_data = r_ns;
            end
            default: begin
               w_addr = GEN_BASE + OFS_CTRL;
               w_data = 32'h1;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_ret      <= ST_WR_TSSH;
         r_sec      <= 48'h0;
         r_ns       <= 32'h0;
         r_seq      <= 16'h0;
         r_sent     <= 32'h0;
         r_overrun  <= 1'b0;
         r_timeout  <= 1'b0;
         r_pending  <= 1'b0;
         r_en_d     <= 1'b0;
         r_period   <= w_reload;
         r_wait_cnt <= 32'h0;
      end else begin
         r_en_d <= enable_i;
         // Period counter free-runs regardless of FSM state
         if (!enable_i || (interval_i == 32'd0) || !r_en_d || w_periodic) begin
            r_period <= w_reload;
         end else begin
            r_period <= r_period - 32'd1;
         end

         if ((r_state != ST_IDLE) && w_trig) begin
            r_pending <= 1'b1;
            r_overrun <= 1'b1;
         end

         case (r_state)
            ST_IDLE: begin
               if (w_go) begin
                  r_sec     <= tod_sec_i;
                  r_ns      <= tod_ns_i;
                  r_pending <= 1'b0;
                  r_state   <= ST_WR_INFO;
               end
            end
            ST_WR_INFO: if (w_done) begin r_ret <= ST_WR_TSSH; r_state <= ST_GAP; end
            ST_WR_TSSH: if (w_done) begin r_ret <= ST_WR_TSSL; r_state <= ST_GAP; end
            ST_WR_TSSL: if (w_done) begin r_ret <= ST_WR_TSNS; r_state <= ST_GAP; end
            ST_WR_TSNS: if (w_done) begin r_ret <= ST_WR_CTRL; r_state <= ST_GAP; end
            ST_WR_CTRL: begin
               if (w_done) begin
                  r_wait_cnt <= 32'h0;
                  r_state    <= ST_WAIT_FRAME;
               end
            end
            ST_GAP: r_state <= r_ret;
            ST_WAIT_FRAME: begin
               if (w_frame) begin
                  r_seq   <= r_seq + 16'd1;
                  r_sent  <= (r_sent == 32'hFFFF_FFFF) ? r_sent : r_sent + 32'd1;
                  r_state <= ST_IDLE;
               end else if (r_wait_cnt == TO_LAST) begin
                  r_timeout <= 1'b1;
                  r_state   <= ST_IDLE;
               end else begin
                  r_wait_cnt <= r_wait_cnt + 32'd1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   ptp_wb_wr_master u_wr (
      .clk     (clk),
      .rst_n   (rst_n),
      .start_i (w_start),
      .addr_i  (w_addr),
      .data_i  (w_data),
      .ack_i   (wbm_ack_i),
      .stb_o   (wbm_stb_o),
      .we_o    (wbm_we_o),
      .addr_o  (wbm_addr_o),
      .data_o  (wbm_data_o),
      .done_o  (w_done)
   );

   assign busy_o     = (r_state != ST_IDLE);
   assign seq_id_o   = r_seq;
   assign sent_cnt_o = r_sent;
   assign overrun_o  = r_overrun;
   assign timeout_o  = r_timeout;

endmodule
